pipeline_hazard_ctrl: RTL and testbench



---
 rtl/pipeline_hazard_ctrl_pkg.sv | 47 ++++
 rtl/pipeline_hazard_ctrl_scoreboard.sv | 59 +++++
 rtl/pipeline_hazard_ctrl.sv | 85 ++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the hazard interlock: register indices, scoreboard entry layout, NOP word.
package pipeline_hazard_ctrl_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] PC_IDX = 5'd31;
  localparam logic [REG_ADDR_W-1:0] LR_IDX = 5'd30;
  localparam logic [REG_ADDR_W-1:0] SP_IDX = 5'd29;

  // Scoreboard entry {v1, a1, v2, a2, pcw}, MSB first.
  localparam int SB_PCW_BIT = 0;
  localparam int SB_A2_LSB  = 1;
  localparam int SB_V2_BIT  = SB_A2_LSB + REG_ADDR_W;
  localparam int SB_A1_LSB  = SB_V2_BIT + 1;
  localparam int SB_V1_BIT  = SB_A1_LSB + REG_ADDR_W;
  localparam int SB_ENTRY_W = SB_V1_BIT + 1;

  typedef struct packed {
    logic                  v1;
    logic [REG_ADDR_W-1:0] a1;
    logic                  v2;
    logic [REG_ADDR_W-1:0] a2;
    logic                  pcw;
  } sb_entry_t;

  // Pipeline-interface word loaded on a bubble: all ops 0, pass = 0.
  localparam int              NOP_W    = 16;
  localparam logic [NOP_W-1:0] NOP_WORD = '0;

  function automatic sb_entry_t make_entry(input logic [1:0]            wr,
                                           input logic [REG_ADDR_W-1:0] wa1,
                                           input logic [REG_ADDR_W-1:0] wa2,
                                           input logic [REG_ADDR_W-1:0] pc_addr);
    sb_entry_t e;
    e.v1  = wr[0];
    e.a1  = wa1;
    e.v2  = wr[1];
    e.a2  = wa2;
    e.pcw = (wr[0] && (wa1 == pc_addr)) || (wr[1] && (wa2 == pc_addr));
    return e;
  endfunction

  function automatic logic entry_hit(input sb_entry_t e, input logic [REG_ADDR_W-1:0] ra);
    return (e.v1 && (e.a1 == ra)) || (e.v2 && (e.a2 == ra));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_scoreboard.sv
// hazard_scoreboard: free-running shift register of in-flight destinations (EX, MEM, WB)
// plus source-address comparators.
module hazard_scoreboard
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int                    DEPTH     = 3,
  parameter int                    WB_BYPASS = 0,
  parameter logic [REG_ADDR_W-1:0] PC_ADDR   = PC_IDX
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [1:0]            dec_write,
  input  logic [REG_ADDR_W-1:0] dec_wa1,
  input  logic [REG_ADDR_W-1:0] dec_wa2,
  input  logic [1:0]            dec_read,
  input  logic [REG_ADDR_W-1:0] dec_ra1,
  input  logic [REG_ADDR_W-1:0] dec_ra2,
  output logic                  raw_0,
  output logic                  raw_1,
  output logic                  pc_pend,
  output logic                  pcw_retire,
  output logic [DEPTH-1:0]      sb_busy
);

  // With a write-through register file the WB slot cannot cause a hazard.
  localparam int CHK_SLOTS = (WB_BYPASS != 0) ? DEPTH - 1 : DEPTH;

  sb_entry_t [DEPTH-1:0] slot_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= '0;
    end else begin
      slot_q[0] <= load ? make_entry(dec_write, dec_wa1, dec_wa2, PC_ADDR) : '0;
      for (int k = 1; k < DEPTH; k++) begin
        slot_q[k] <= slot_q[k-1];
      end
    end
  end

  always_comb begin
    raw_0   = 1'b0;
    raw_1   = 1'b0;
    pc_pend = 1'b0;
    sb_busy = '0;
    for (int k = 0; k < DEPTH; k++) begin
      sb_busy[k] = slot_q[k].v1 | slot_q[k].v2;
      pc_pend    = pc_pend | slot_q[k].pcw;
      if (k < CHK_SLOTS) begin
        raw_0 = raw_0 | (dec_read[0] & entry_hit(slot_q[k], dec_ra1));
        raw_1 = raw_1 | (dec_read[1] & entry_hit(slot_q[k], dec_ra2));
      end
    end
  end

  assign pcw_retire = slot_q[DEPTH-1].pcw;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Decode-stage interlock: stalls on RAW hazards and pending PC writes, flushes after a PC write retires.
// Optional stall/flush counters under `HAZARD_STALL_CNT_EN.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int                    DEPTH     = 3,
  parameter int                    WB_BYPASS = 0,
  parameter logic [REG_ADDR_W-1:0] PC_ADDR   = PC_IDX
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dec_valid,
  input  logic [REG_ADDR_W-1:0] dec_ra1,
  input  logic [REG_ADDR_W-1:0] dec_ra2,
  input  logic [1:0]            dec_read,
  input  logic [REG_ADDR_W-1:0] dec_wa1,
  input  logic [REG_ADDR_W-1:0] dec_wa2,
  input  logic [1:0]            dec_write,
  output logic                  stall,
  output logic                  bubble,
  output logic                  flush,
  output logic                  issue,
`ifdef HAZARD_STALL_CNT_EN
  output logic [31:0]           stall_cycles,
  output logic [15:0]           flush_count,
`endif
  output logic [DEPTH-1:0]      sb_busy
);

  logic raw_0;
  logic raw_1;
  logic pc_pend;
  logic pcw_retire;

  hazard_scoreboard #(
    .DEPTH     (DEPTH),
    .WB_BYPASS (WB_BYPASS),
    .PC_ADDR   (PC_ADDR)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .load       (issue),
    .dec_write  (dec_write),
    .dec_wa1    (dec_wa1),
    .dec_wa2    (dec_wa2),
    .dec_read   (dec_read),
    .dec_ra1    (dec_ra1),
    .dec_ra2    (dec_ra2),
    .raw_0      (raw_0),
    .raw_1      (raw_1),
    .pc_pend    (pc_pend),
    .pcw_retire (pcw_retire),
    .sb_busy    (sb_busy)
  );

  assign stall  = (dec_valid & (raw_0 | raw_1)) | pc_pend | flush;
  assign issue  = dec_valid & ~stall;
  assign bubble = ~issue;

  // One-cycle flush after the PC-writing entry drops out of the last slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush <= 1'b0;
    end else begin
      flush <= pcw_retire;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (flush && (flush_count != 16'hFFFF)) begin
        flush_count <= flush_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: one instance with WB_BYPASS = 0, one with WB_BYPASS = 1.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       dec_valid;
  logic [4:0] dec_ra1, dec_ra2, dec_wa1, dec_wa2;
  logic [1:0] dec_read, dec_write;

  logic       stall, bubble, flush, issue;
  logic [2:0] sb_busy;
  logic       stall_b, bubble_b, flush_b, issue_b;
  logic [2:0] sb_busy_b;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cycles, stall_cycles_b;
  logic [15:0] flush_count, flush_count_b;
  logic [31:0] base_stall;
  logic [15:0] base_flush;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.DEPTH(3), .WB_BYPASS(0), .PC_ADDR(5'd31)) uut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid),
    .dec_ra1(dec_ra1), .dec_ra2(dec_ra2), .dec_read(dec_read),
    .dec_wa1(dec_wa1), .dec_wa2(dec_wa2), .dec_write(dec_write),
    .stall(stall), .bubble(bubble), .flush(flush), .issue(issue),
`ifdef HAZARD_STALL_CNT_EN
    .stall_cycles(stall_cycles), .flush_count(flush_count),
`endif
    .sb_busy(sb_busy)
  );

  pipeline_hazard_ctrl #(.DEPTH(3), .WB_BYPASS(1), .PC_ADDR(5'd31)) uut_byp (
    .clk(clk), .rst(rst), .dec_valid(dec_valid),
    .dec_ra1(dec_ra1), .dec_ra2(dec_ra2), .dec_read(dec_read),
    .dec_wa1(dec_wa1), .dec_wa2(dec_wa2), .dec_write(dec_write),
    .stall(stall_b), .bubble(bubble_b), .flush(flush_b), .issue(issue_b),
`ifdef HAZARD_STALL_CNT_EN
    .stall_cycles(stall_cycles_b), .flush_count(flush_count_b),
`endif
    .sb_busy(sb_busy_b)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_ctrl(input string tag, input bit exp_stall, input bit exp_issue,
                             input bit exp_flush);
    check_val({tag, "_stall"},  32'(stall),  32'(exp_stall));
    check_val({tag, "_issue"},  32'(issue),  32'(exp_issue));
    check_val({tag, "_bubble"}, 32'(bubble), 32'(!exp_issue));
    check_val({tag, "_flush"},  32'(flush),  32'(exp_flush));
  endtask

  task automatic drive(input bit v, input int rd, input int ra1, input int ra2,
                       input int wr, input int wa1, input int wa2);
    dec_valid = v;
    dec_read  = 2'(rd);
    dec_ra1   = 5'(ra1);
    dec_ra2   = 5'(ra2);
    dec_write = 2'(wr);
    dec_wa1   = 5'(wa1);
    dec_wa2   = 5'(wa2);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (n) next_cycle();
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    next_cycle();
    rst = 1'b0;

    // Reset state with an empty decoder
    @(negedge clk);
    check_val("rst_sb_busy", 32'(sb_busy), 32'd0);
    expect_ctrl("rst", 0, 0, 0);
    next_cycle();

    // Scenario 1: write r3, then read r3 on ra1
`ifdef HAZARD_STALL_CNT_EN
    base_stall = stall_cycles;
`endif
    drive(1, 0, 0, 0, 1, 3, 0);
    @(negedge clk);
    expect_ctrl("s1_prod", 0, 1, 0);
    next_cycle();
    drive(1, 1, 3, 0, 0, 0, 0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      expect_ctrl($sformatf("s1_t%0d", c), c < 4, c == 4, 0);
      if (c <= 3) check_val($sformatf("s1_byp_issue_t%0d", c), 32'(issue_b), 32'(c == 3));
      next_cycle();
    end
    idle(5);
`ifdef HAZARD_STALL_CNT_EN
    check_val("s1_stall_cycles", stall_cycles - base_stall, 32'd3);
`endif

    // Scenario 2: four independent instructions back to back
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 10 + i, 0, 1, 1 + i, 0);
      @(negedge clk);
      expect_ctrl($sformatf("s2_i%0d", i), 0, 1, 0);
      if (i == 3) check_val("s2_sb_busy", 32'(sb_busy), 32'b111);
      next_cycle();
    end
    idle(5);

    // Scenario 3: PC write with a valid instruction waiting behind it
`ifdef HAZARD_STALL_CNT_EN
    base_stall = stall_cycles;
    base_flush = flush_count;
`endif
    drive(1, 0, 0, 0, 1, 31, 0);
    @(negedge clk);
    expect_ctrl("s3_prod", 0, 1, 0);
    next_cycle();
    drive(1, 0, 0, 0, 1, 20, 0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      expect_ctrl($sformatf("s3_t%0d", c), c <= 4, c == 5, c == 4);
      check_val($sformatf("s3_byp_flush_t%0d", c), 32'(flush_b), 32'(c == 4));
      next_cycle();
    end
    idle(5);
`ifdef HAZARD_STALL_CNT_EN
    check_val("s3_stall_cycles", stall_cycles - base_stall, 32'd4);
    check_val("s3_flush_count", 32'(flush_count - base_flush), 32'd1);
`endif

    // Scenario 4a: dual write r5/r6, read r6 on ra2
    drive(1, 0, 0, 0, 3, 5, 6);
    @(negedge clk);
    expect_ctrl("s4_prod", 0, 1, 0);
    next_cycle();
    drive(1, 2, 0, 6, 0, 0, 0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      expect_ctrl($sformatf("s4_t%0d", c), c < 4, c == 4, 0);
      next_cycle();
    end
    idle(5);

    // Scenario 4b: dual write r5/r6, unrelated read r7, then read r5 on ra1
    drive(1, 0, 0, 0, 3, 5, 6);
    @(negedge clk);
    expect_ctrl("s4b_prod", 0, 1, 0);
    next_cycle();
    drive(1, 2, 0, 7, 0, 0, 0);
    @(negedge clk);
    expect_ctrl("s4b_r7", 0, 1, 0);
    next_cycle();
    drive(1, 1, 5, 0, 0, 0, 0);
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      expect_ctrl($sformatf("s4b_t%0d", c), c < 4, c == 4, 0);
      next_cycle();
    end
    idle(5);

    // Both sources hazard on different producers: stall until the later one clears
    drive(1, 0, 0, 0, 1, 8, 0);
    next_cycle();
    drive(1, 0, 0, 0, 1, 9, 0);
    next_cycle();
    drive(1, 3, 8, 9, 0, 0, 0);
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      expect_ctrl($sformatf("dual_t%0d", c), c < 5, c == 5, 0);
      next_cycle();
    end
    idle(5);

    // Pending PC write with an empty decoder still stalls
    drive(1, 0, 0, 0, 2, 0, 31);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    expect_ctrl("pcidle_t1", 1, 0, 0);
    next_cycle();
    next_cycle();
    next_cycle();
    @(negedge clk);
    expect_ctrl("pcidle_t4", 1, 0, 1);
    next_cycle();
    idle(3);

    // Scenario 5: reset in the middle of a PC-write stall
    drive(1, 0, 0, 0, 1, 31, 0);
    next_cycle();
    drive(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    expect_ctrl("s5_t1", 1, 0, 0);
    next_cycle();
    rst = 1'b1;
    #1;
    check_val("s5_rst_sb_busy", 32'(sb_busy), 32'd0);
    check_val("s5_rst_stall", 32'(stall), 32'd0);
    check_val("s5_rst_flush", 32'(flush), 32'd0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check_val($sformatf("s5_post_flush_%0d", c), 32'(flush), 32'd0);
      check_val($sformatf("s5_post_stall_%0d", c), 32'(stall), 32'd0);
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
